// File: rtl/div_tick_timer.sv
// div_tick_timer: turns the divided clock into tick strobes on the fast clock
// and counts them in a programmable down-counter with one-shot/auto-reload
// expiry, a one-cycle expire strobe and a sticky irq.
//
// state | meaning
// ------+----------------------------------------------
// IDLE  | counter parked, ticks still generated, busy=0
// RUN   | counter consumes ticks, busy=1
module div_tick_timer #(
  parameter int WIDTH     = 8,
  parameter int EDGE_MODE = 0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clk_div,
  input  logic             start,
  input  logic             stop,
  input  logic             auto_reload,
  input  logic [WIDTH-1:0] load_val,
  input  logic             irq_ack,
  output logic             tick,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             expire,
  output logic             irq
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic             clk_div_q, clk_div_d;
  logic             tick_q, tick_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             busy_q, busy_d;
  logic             expire_q, expire_d;
  logic             irq_q, irq_d;

  // Edge detect: clk_div is already synchronous to clk, so one history flop suffices.
  always_comb begin
    clk_div_d = clk_div;
    if (EDGE_MODE != 0) begin
      tick_d = clk_div ^ clk_div_q;
    end else begin
      tick_d = clk_div & ~clk_div_q;
    end
  end

  // Next-state, counter and strobe logic; the FSM consumes the registered tick.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    expire_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !stop) begin
          count_d = load_val;
          state_d = RUN;
        end
      end
      RUN: begin
        if (stop) begin
          state_d = IDLE;
        end else if (start) begin
          // restart has priority over a coincident tick
          count_d = load_val;
        end else if (tick_q) begin
          if (count_q != '0) begin
            count_d = count_q - {{(WIDTH-1){1'b0}}, 1'b1};
          end else begin
            expire_d = 1'b1;
            if (auto_reload) begin
              count_d = load_val;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // busy decodes the next state so it drops in the same cycle as a one-shot expire
    busy_d = (state_d == RUN);
    // a new expiry outranks a simultaneous acknowledge
    irq_d  = expire_d | (irq_q & ~irq_ack);
  end

  // State and output registers, all cleared asynchronously.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      clk_div_q <= 1'b0;
      tick_q    <= 1'b0;
      count_q   <= '0;
      busy_q    <= 1'b0;
      expire_q  <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      clk_div_q <= clk_div_d;
      tick_q    <= tick_d;
      count_q   <= count_d;
      busy_q    <= busy_d;
      expire_q  <= expire_d;
      irq_q     <= irq_d;
    end
  end

  assign tick   = tick_q;
  assign count  = count_q;
  assign busy   = busy_q;
  assign expire = expire_q;
  assign irq    = irq_q;

endmodule

// File: tb/tb_div_tick_timer.sv
// Directed bench for div_tick_timer with a mod-3 divider model (clk_div period 6 clks).
// Inputs change at negedges; outputs are sampled at negedges.
module tb_div_tick_timer;

  logic       clk;
  logic       rstn;
  logic       clk_div;
  logic       start;
  logic       stop;
  logic       auto_reload;
  logic [7:0] load_val;
  logic       irq_ack;

  logic       tick0, busy0, expire0, irq0;
  logic [7:0] count0;
  logic       tick1, busy1, expire1, irq1;
  logic [7:0] count1;

  int checks = 0;
  int errors = 0;
  int div_cnt;

  div_tick_timer #(.WIDTH(8), .EDGE_MODE(0)) dut0 (
    .clk(clk), .rstn(rstn), .clk_div(clk_div), .start(start), .stop(stop),
    .auto_reload(auto_reload), .load_val(load_val), .irq_ack(irq_ack),
    .tick(tick0), .count(count0), .busy(busy0), .expire(expire0), .irq(irq0)
  );

  div_tick_timer #(.WIDTH(8), .EDGE_MODE(1)) dut1 (
    .clk(clk), .rstn(rstn), .clk_div(clk_div), .start(start), .stop(stop),
    .auto_reload(auto_reload), .load_val(load_val), .irq_ack(irq_ack),
    .tick(tick1), .count(count1), .busy(busy1), .expire(expire1), .irq(irq1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Mod-3 divider model: toggles clk_div every 3 clks, held low in reset.
  initial begin
    clk_div = 1'b0;
    div_cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!rstn) begin
        div_cnt = 0;
        clk_div = 1'b0;
      end else if (div_cnt == 2) begin
        div_cnt = 0;
        clk_div = ~clk_div;
      end else begin
        div_cnt = div_cnt + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Returns at the first negedge where clk_div is seen high after being low.
  task automatic wait_rise();
    logic prev;
    logic found;
    prev  = clk_div;
    found = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (clk_div && !prev) begin
        found = 1'b1;
        break;
      end
      prev = clk_div;
    end
    chk("wait_rise_timeout", {31'd0, found}, 32'd1);
  endtask

  initial begin
    rstn        = 1'b0;
    start       = 1'b0;
    stop        = 1'b0;
    auto_reload = 1'b0;
    load_val    = 8'd0;
    irq_ack     = 1'b0;

    // reset state
    nc(2);
    chk("rst_tick",   {31'd0, tick0},   32'd0);
    chk("rst_count",  {24'd0, count0},  32'd0);
    chk("rst_busy",   {31'd0, busy0},   32'd0);
    chk("rst_expire", {31'd0, expire0}, 32'd0);
    chk("rst_irq",    {31'd0, irq0},    32'd0);
    rstn = 1'b1;
    nc(1);
    chk("rel_tick", {31'd0, tick0}, 32'd0);

    // EDGE_MODE=0 tick pattern: high 1 clk after the rise, none on the fall
    wait_rise();
    for (int i = 1; i <= 12; i++) begin
      nc(1);
      chk($sformatf("t2_tick_%0d", i), {31'd0, tick0}, (i == 1 || i == 7) ? 32'd1 : 32'd0);
    end

    // one-shot, load_val=2
    wait_rise();
    load_val = 8'd2; auto_reload = 1'b0; start = 1'b1;
    nc(1); start = 1'b0;
    chk("t3_count_a", {24'd0, count0}, 32'd2);
    chk("t3_busy_a",  {31'd0, busy0},  32'd1);
    chk("t3_tick_a",  {31'd0, tick0},  32'd1);
    nc(1);
    chk("t3_count_b", {24'd0, count0}, 32'd1);
    nc(6);
    chk("t3_count_c", {24'd0, count0}, 32'd0);
    chk("t3_busy_c",  {31'd0, busy0},  32'd1);
    chk("t3_expire_c", {31'd0, expire0}, 32'd0);
    nc(6);
    chk("t3_expire", {31'd0, expire0}, 32'd1);
    chk("t3_irq",    {31'd0, irq0},    32'd1);
    chk("t3_busy",   {31'd0, busy0},   32'd0);
    chk("t3_count",  {24'd0, count0},  32'd0);
    nc(1);
    chk("t3_expire_end", {31'd0, expire0}, 32'd0);
    chk("t3_irq_hold",   {31'd0, irq0},    32'd1);
    irq_ack = 1'b1;
    nc(1); irq_ack = 1'b0;
    chk("t3_irq_ack", {31'd0, irq0}, 32'd0);

    // auto-reload load_val=1, then 3; irq_ack together with expire
    wait_rise();
    load_val = 8'd1; auto_reload = 1'b1; start = 1'b1;
    nc(1); start = 1'b0;
    chk("t4_count_1", {24'd0, count0}, 32'd1);
    chk("t4_busy_1",  {31'd0, busy0},  32'd1);
    nc(7);
    chk("t4_expire_8", {31'd0, expire0}, 32'd1);
    chk("t4_count_8",  {24'd0, count0},  32'd1);
    chk("t4_busy_8",   {31'd0, busy0},   32'd1);
    nc(1);
    chk("t4_expire_9", {31'd0, expire0}, 32'd0);
    load_val = 8'd3;
    nc(1); irq_ack = 1'b1;
    nc(1); irq_ack = 1'b0;
    chk("t4_irq_11", {31'd0, irq0}, 32'd0);
    nc(8); irq_ack = 1'b1;
    nc(1); irq_ack = 1'b0;
    chk("t5_expire_20", {31'd0, expire0}, 32'd1);
    chk("t5_irq_set_wins", {31'd0, irq0}, 32'd1);
    chk("t4_count_20", {24'd0, count0}, 32'd3);
    nc(12);
    chk("t4_count_32",  {24'd0, count0},  32'd1);
    chk("t4_expire_32", {31'd0, expire0}, 32'd0);
    nc(12);
    chk("t4_expire_44", {31'd0, expire0}, 32'd1);
    chk("t4_busy_44",   {31'd0, busy0},   32'd1);
    chk("t4_count_44",  {24'd0, count0},  32'd3);
    nc(1); stop = 1'b1;
    nc(1); stop = 1'b0;
    chk("t4_stop_busy",  {31'd0, busy0},  32'd0);
    chk("t4_stop_count", {24'd0, count0}, 32'd3);
    for (int i = 0; i < 14; i++) begin
      nc(1);
      chk($sformatf("t4_frozen_exp_%0d", i), {31'd0, expire0}, 32'd0);
      chk($sformatf("t4_frozen_cnt_%0d", i), {24'd0, count0},  32'd3);
    end

    // start and stop together from IDLE
    load_val = 8'd5; start = 1'b1; stop = 1'b1;
    nc(1); start = 1'b0; stop = 1'b0;
    chk("t5_ss_busy",  {31'd0, busy0},  32'd0);
    chk("t5_ss_count", {24'd0, count0}, 32'd3);

    // reset asserted mid-RUN with count=3, irq=1
    wait_rise();
    load_val = 8'd3; auto_reload = 1'b0; start = 1'b1;
    nc(1); start = 1'b0;
    chk("t1_pre_count", {24'd0, count0}, 32'd3);
    chk("t1_pre_busy",  {31'd0, busy0},  32'd1);
    chk("t1_pre_irq",   {31'd0, irq0},   32'd1);
    rstn = 1'b0;
    #1;
    chk("t1_tick",   {31'd0, tick0},   32'd0);
    chk("t1_count",  {24'd0, count0},  32'd0);
    chk("t1_busy",   {31'd0, busy0},   32'd0);
    chk("t1_expire", {31'd0, expire0}, 32'd0);
    chk("t1_irq",    {31'd0, irq0},    32'd0);
    chk("t1_tick_e1", {31'd0, tick1},  32'd0);
    nc(2); rstn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      nc(1);
      chk($sformatf("t1_idle_busy_%0d", i), {31'd0, busy0},   32'd0);
      chk($sformatf("t1_idle_exp_%0d", i),  {31'd0, expire0}, 32'd0);
    end

    // EDGE_MODE=1, load_val=0, auto-reload: tick every 3 clks, expire every tick
    wait_rise();
    load_val = 8'd0; auto_reload = 1'b1; start = 1'b1;
    nc(1); start = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      if (i > 1) nc(1);
      chk($sformatf("t6_tick_%0d", i),   {31'd0, tick1},   (i % 3 == 1) ? 32'd1 : 32'd0);
      chk($sformatf("t6_expire_%0d", i), {31'd0, expire1}, (i % 3 == 2) ? 32'd1 : 32'd0);
      chk($sformatf("t6_count_%0d", i),  {24'd0, count1},  32'd0);
      chk($sformatf("t6_busy_%0d", i),   {31'd0, busy1},   32'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
